// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Arbitrates one single-ported unified instruction/data memory between the
// fetch stage (I-port) and the memory stage (D-port). A three-state FSM
// (IDLE -> WAIT -> RESP) grants the port, holds the registered memory request
// until the memory acknowledges, returns the read data with a one-cycle done
// pulse, and a watchdog aborts any access that waits TIMEOUT cycles.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_req/i_addr        fetch request (level) and address
//   i_done/i_rdata      fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request, store enable, address, store data
//   d_done/d_rdata      data completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request bundle
//   mem_ack/mem_rdata   one-cycle memory acknowledge with read data
//   stall_f/stall_m     stall requests to fetch/decode and memory stages
//   busy                FSM is not in IDLE
//   err                 sticky watchdog-expired flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_f,
    output logic          stall_m,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Port identifiers for owner/last registers
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_e          state_q;
    logic            owner_q;
    logic            last_q;
    logic [CW-1:0]   cnt_q;
    logic            i_done_q;
    logic            d_done_q;
    logic [DW-1:0]   i_rdata_q;
    logic [DW-1:0]   d_rdata_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            err_q;

    logic            gnt_any_s;
    logic            owner_d;

    // Grant selection: a tie goes to the port that was not served last
    always_comb begin
        gnt_any_s = i_req | d_req;
        owner_d   = OWN_I;
        if (d_req && (!i_req || (last_q == OWN_I))) begin
            owner_d = OWN_D;
        end else begin
            owner_d = OWN_I;
        end
    end

    // Arbitration FSM with registered memory bundle, done pulses and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            last_q      <= OWN_I;
            cnt_q       <= {CW{1'b0}};
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= {DW{1'b0}};
            d_rdata_q   <= {DW{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    if (gnt_any_s) begin
                        owner_q     <= owner_d;
                        last_q      <= owner_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (owner_d == OWN_D) ? d_we : 1'b0;
                        mem_addr_q  <= (owner_d == OWN_D) ? d_addr : i_addr;
                        mem_wdata_q <= (owner_d == OWN_D) ? d_wdata : {DW{1'b0}};
                        cnt_q       <= {CW{1'b0}};
                        state_q     <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // An ack in the timeout cycle still counts as normal completion
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (owner_q == OWN_D) begin
                            d_rdata_q <= mem_we_q ? {DW{1'b0}} : mem_rdata;
                            d_done_q  <= 1'b1;
                        end else begin
                            i_rdata_q <= mem_rdata;
                            i_done_q  <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else if (cnt_q == CNT_MAX) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        if (owner_q == OWN_D) begin
                            d_rdata_q <= {DW{1'b0}};
                            d_done_q  <= 1'b1;
                        end else begin
                            i_rdata_q <= {DW{1'b0}};
                            i_done_q  <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    i_done_q  <= 1'b0;
                    d_done_q  <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);
    // Stalls see the requester's level against the registered done only
    assign stall_f   = i_req & ~i_done_q;
    assign stall_m   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (TIMEOUT=4). Inputs change 1 time unit
// after the rising edge; outputs are sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_m(stall_m), .busy(busy), .err(err)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (drive point)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move from the drive point to the falling-edge sample point
    task automatic probe();
        #4;
    endtask

    logic [31:0] words [4];
    logic        exp_d;

    initial begin
        words[0] = 32'hA0A0_0001;
        words[1] = 32'hB1B1_0002;
        words[2] = 32'hC2C2_0003;
        words[3] = 32'hD3D3_0004;

        rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick(); tick(); probe();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_i_done", i_done, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);

        // ---- Tie and alternation: D, I, D, I, each done 3 cycles apart
        tick();
        rst_n = 1'b1; i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            probe();
            chk1("tie_idle_req", mem_req, 1'b0);
            tick();
            mem_ack = 1'b1; mem_rdata = words[k];
            probe();
            chk1("tie_mem_req", mem_req, 1'b1);
            chk32("tie_addr", mem_addr, exp_d ? 32'h300 : 32'h200);
            tick();
            mem_ack = 1'b0; mem_rdata = 32'h0;
            probe();
            chk1("tie_d_done", d_done, exp_d);
            chk1("tie_i_done", i_done, !exp_d);
            chk32("tie_rdata", exp_d ? d_rdata : i_rdata, words[k]);
            chk1("tie_stall_f", stall_f, exp_d);
            chk1("tie_stall_m", stall_m, !exp_d);
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;

        // ---- Single load
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        probe();
        chk1("ld_c0_mem_req", mem_req, 1'b0);
        chk1("ld_c0_stall_m", stall_m, 1'b1);
        tick(); probe();
        chk1("ld_c1_mem_req", mem_req, 1'b1);
        chk32("ld_c1_addr", mem_addr, 32'h100);
        chk1("ld_c1_we", mem_we, 1'b0);
        chk1("ld_c1_busy", busy, 1'b1);
        tick(); probe();
        chk1("ld_c2_mem_req", mem_req, 1'b1);
        chk1("ld_c2_d_done", d_done, 1'b0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        probe();
        chk1("ld_c3_mem_req", mem_req, 1'b1);
        chk1("ld_c3_stall_m", stall_m, 1'b1);
        chk1("ld_c3_d_done", d_done, 1'b0);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        probe();
        chk1("ld_c4_d_done", d_done, 1'b1);
        chk32("ld_c4_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk1("ld_c4_mem_req", mem_req, 1'b0);
        chk1("ld_c4_stall_m", stall_m, 1'b0);
        tick();
        d_req = 1'b0;
        probe();
        chk1("ld_c5_busy", busy, 1'b0);
        chk1("ld_c5_d_done", d_done, 1'b0);
        chk32("ld_c5_hold", d_rdata, 32'hDEAD_BEEF);

        // ---- Store with fetch request raised mid-access
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        tick();
        i_req = 1'b1; i_addr = 32'h80;
        probe();
        chk1("st_c1_we", mem_we, 1'b1);
        chk32("st_c1_wdata", mem_wdata, 32'h1234_5678);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        probe();
        chk32("st_c2_addr", mem_addr, 32'h40);
        chk1("st_c2_we", mem_we, 1'b1);
        chk1("st_c2_stall_f", stall_f, 1'b1);
        tick();
        mem_ack = 1'b0;
        probe();
        chk1("st_c3_d_done", d_done, 1'b1);
        chk32("st_c3_d_rdata", d_rdata, 32'h0);
        chk1("st_c3_mem_req", mem_req, 1'b0);
        tick();
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
        probe();
        chk1("st_c4_mem_req", mem_req, 1'b0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        probe();
        chk1("st_c5_mem_req", mem_req, 1'b1);
        chk32("st_c5_addr", mem_addr, 32'h80);
        chk1("st_c5_we", mem_we, 1'b0);
        chk32("st_c5_wdata", mem_wdata, 32'h0);
        tick();
        mem_ack = 1'b0;
        probe();
        chk1("st_c6_i_done", i_done, 1'b1);
        chk32("st_c6_i_rdata", i_rdata, 32'h0BAD_F00D);
        tick();
        i_req = 1'b0;

        // ---- Watchdog expiry (TIMEOUT=4)
        tick();
        i_req = 1'b1; i_addr = 32'h44;
        for (int c = 1; c <= 4; c++) begin
            tick(); probe();
            chk1("wd_mem_req", mem_req, 1'b1);
            chk1("wd_i_done", i_done, 1'b0);
            chk1("wd_err_low", err, 1'b0);
        end
        tick(); probe();
        chk1("wd_c5_mem_req", mem_req, 1'b0);
        chk1("wd_c5_i_done", i_done, 1'b1);
        chk32("wd_c5_i_rdata", i_rdata, 32'h0);
        chk1("wd_c5_err", err, 1'b1);
        tick();
        i_req = 1'b0;
        probe();
        chk1("wd_c6_busy", busy, 1'b0);

        // ---- Successful access after expiry keeps err set
        tick();
        d_req = 1'b1; d_addr = 32'h10;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h7777_8888;
        tick();
        mem_ack = 1'b0;
        probe();
        chk1("wd_ok_done", d_done, 1'b1);
        chk32("wd_ok_rdata", d_rdata, 32'h7777_8888);
        chk1("wd_ok_err_sticky", err, 1'b1);
        tick();
        d_req = 1'b0;

        // ---- Async reset mid-WAIT
        tick();
        i_req = 1'b1; i_addr = 32'h90;
        tick(); probe();
        chk1("ar_pre_mem_req", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("ar_mem_req", mem_req, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        chk1("ar_err", err, 1'b0);
        tick(); probe();
        chk1("ar_no_i_done", i_done, 1'b0);
        chk32("ar_i_rdata", i_rdata, 32'h0);

        // ---- After release: tie grants D; ack on 4th WAIT cycle completes normally
        tick();
        rst_n = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        tick(); probe();
        chk32("ar_tie_addr", mem_addr, 32'h10);
        tick();
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
        probe();
        chk1("edge_c4_mem_req", mem_req, 1'b1);
        tick();
        mem_ack = 1'b0;
        probe();
        chk1("edge_d_done", d_done, 1'b1);
        chk32("edge_d_rdata", d_rdata, 32'h55AA_55AA);
        chk1("edge_err", err, 1'b0);
        chk1("edge_i_done", i_done, 1'b0);
        tick();
        i_req = 1'b0; d_req = 1'b0;

        // ---- Spurious acks in RESP and IDLE
        tick();
        i_req = 1'b1; i_addr = 32'h8;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rdata = 32'h3333_4444;
        probe();
        chk1("sp_resp_i_done", i_done, 1'b1);
        chk32("sp_resp_i_rdata", i_rdata, 32'h1111_2222);
        tick();
        i_req = 1'b0;
        probe();
        chk1("sp_idle_busy", busy, 1'b0);
        chk1("sp_idle_i_done", i_done, 1'b0);
        chk32("sp_idle_i_rdata", i_rdata, 32'h1111_2222);
        tick();
        probe();
        chk1("sp_idle2_mem_req", mem_req, 1'b0);
        chk1("sp_idle2_busy", busy, 1'b0);
        chk32("sp_idle2_d_rdata", d_rdata, 32'h55AA_55AA);
        chk1("sp_idle2_err", err, 1'b0);
        tick();
        mem_ack = 1'b0;
        probe();
        chk1("sp_end_d_done", d_done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified instruction/data memory between the fetch stage (I-port) and the memory stage (D-port) of the pipelined MIPS core. A three-state FSM grants the port, holds the memory request until the memory acknowledges, returns the read data, and drives stall requests that the hazard logic ORs into the fetch/decode stall and memory-stage stall terms. A watchdog bounds every memory access.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 64, maximum cycles spent in WAIT before an access is aborted (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request, level, held until i_done
- i_addr  in  AW  fetch address
- i_done  out  1  one-cycle completion pulse to fetch
- i_rdata  out  DW  fetched word, valid while i_done=1
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_done  out  1  one-cycle completion pulse to memory stage
- d_rdata  out  DW  load data, valid while d_done=1
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_ack  in  1  one-cycle acknowledge from memory; mem_rdata valid same cycle
- mem_rdata  in  DW  memory read data
- stall_f  out  1  i_req & ~i_done
- stall_m  out  1  d_req & ~d_done
- busy  out  1  FSM not IDLE
- err  out  1  sticky watchdog flag

## Operation
- States: IDLE, WAIT, RESP. Register `owner` (I/D) and `last` (I/D, reset I).
- IDLE: if no request, stay. If only one requests, grant it. If both request, grant the one ≠ `last` (reset value I ⇒ first tie goes to D). On grant: latch owner's addr/we/wdata into mem_* (I-port: mem_we=0, mem_wdata=0), set mem_req=1, clear watchdog counter, `last`←owner, go WAIT.
- WAIT: mem_* held stable. On mem_ack: mem_req←0, capture mem_rdata into owner's rdata register (D-port stores capture 0), go RESP. No ack: counter+1; when counter reaches TIMEOUT−1 without ack: mem_req←0, owner's rdata register←0, err←1, go RESP. Ack in the same cycle as timeout wins (normal completion, err unchanged).
- RESP: assert owner's done for exactly this cycle, go IDLE. Requester must drop req or present a new request from the next cycle; a req seen in the following IDLE is a new transaction.
- mem_ack outside WAIT is ignored.
- i_rdata/d_rdata hold their last captured value when done=0.
- Counter width: clog2(TIMEOUT)+1, saturation not needed.
- err clears only on reset.

## Timing
- Reset (async, immediate): state IDLE, mem_req/mem_we=0, mem_addr/mem_wdata=0, i_done/d_done=0, i_rdata/d_rdata=0, busy=0, err=0, last=I, counter=0. stall_f/stall_m follow inputs combinationally. Reset mid-WAIT drops mem_req in the same instant; in-flight access is abandoned, no done issued.
- Request in IDLE at cycle 0 ⇒ mem_req=1 from cycle 1. Ack in cycle n (n≥1) ⇒ done=1 and rdata valid in cycle n+1 ⇒ IDLE in cycle n+2. Minimum req-to-done: 2 cycles; back-to-back grants every 3 cycles minimum.
- Timeout: WAIT spans at most TIMEOUT cycles; done (rdata=0) in cycle TIMEOUT+1, err high from that cycle.
- stall_f/stall_m are combinational from req and the registered done; no combinational path from mem_ack to any output.

## Test plan
- Single load: d_req=1, d_we=0, d_addr=0x100; memory acks in cycle 3 with 0xDEADBEEF -> mem_req cycles 1–3, mem_addr=0x100, d_done only in cycle 4 with d_rdata=0xDEADBEEF, stall_m=1 cycles 0–3, busy=0 in cycle 5.
- Tie and alternation: i_req and d_req both held, ack after 1 cycle each -> grant order D, I, D, I; each done 3 cycles apart; i_rdata/d_rdata match returned words.
- Store: d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678 throughout WAIT; d_done with d_rdata=0; i_req raised mid-store is granted only after RESP.
- Watchdog: TIMEOUT=4, i_req, no ack -> mem_req high exactly 4 cycles, i_done with i_rdata=0 in cycle 5, err=1 and stays 1 across later successful accesses; ack on the 4th WAIT cycle instead -> normal completion, err=0.
- Async reset: assert rst_n=0 mid-WAIT (between clock edges) -> mem_req, busy fall immediately, no done pulse; after release, first tie grants D.
- Spurious mem_ack in IDLE/RESP -> no state change, no done, rdata registers unchanged.
